// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction encoder: supported RV32I opcodes,
// the instruction word type and the encoder FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OPCODE_LW    = 7'b0000011;
    localparam logic [6:0] OPCODE_SW    = 7'b0100011;
    localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;

    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } enc_state_t;

    // True when imm is representable as a 12-bit signed immediate.
    function automatic logic imm12_fits(input logic [31:0] imm);
        return imm == {{20{imm[11]}}, imm[11:0]};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational packer: scatters instruction fields into an RV32I word.
// I-type (LW, OP-IMM) and S-type (SW) are supported; anything else is flagged
// as not legal and produces an all-zero word.
// Build option: INSTR_ENCODER_RANGE_CHECK_EN -- when defined, an immediate
// outside -2048..2047 also makes the bundle not legal; when undefined the
// immediate is silently truncated to imm[11:0].
// Ports:
//   opcode [6:0], funct3 [2:0], rd/rs1/rs2 [4:0], imm [31:0]  - fields in
//   word   [31:0]  - encoded instruction
//   legal          - bundle may be written
// -----------------------------------------------------------------------------
module instr_pack
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output instr_t      word,
    output logic        legal
);

    logic imm_ok;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    assign imm_ok = imm12_fits(imm);
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:12];
    assign imm_ok        = 1'b1;
`endif

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (opcode)
            OPCODE_LW, OPCODE_OPIMM: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = imm_ok;
            end
            OPCODE_SW: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = imm_ok;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts instruction field bundles over a valid/ready handshake, encodes them
// with instr_pack and writes the words to instruction memory at successive
// word addresses starting at 0. Stops (FULL) after address DEPTH-1 is written.
// Rejected bundles (unsupported opcode, or out-of-range immediate when
// INSTR_ENCODER_RANGE_CHECK_EN is defined) are consumed and set sticky o_err.
// Ports:
//   i_clk, i_arst_n       clock, async active-low reset
//   i_clear               sync clear of pointer/count/error, FSM to IDLE
//   i_valid / o_ready     bundle handshake
//   i_opcode..i_imm       instruction fields
//   o_memWrEn/o_memAddr/o_memWrData  one-cycle write port, 1 cycle latency
//   o_count               words written since reset/clear
//   o_err                 sticky rejection flag
//
// state | meaning
// IDLE  | no write issued last cycle, accepting
// WRITE | write strobe active this cycle, accepting (back-to-back)
// FULL  | DEPTH words written, accepting nothing until i_clear
// -----------------------------------------------------------------------------
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_clear,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    output logic              o_memWrEn,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [31:0]       o_memWrData,
    output logic [ADDR_W:0]   o_count,
    output logic              o_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);

    enc_state_t state, state_nxt;
    instr_t     word;
    logic       legal;
    logic       accept;
    logic       wr;
    logic       rej;

    instr_pack u_pack (
        .opcode (i_opcode),
        .funct3 (i_funct3),
        .rd     (i_rd),
        .rs1    (i_rs1),
        .rs2    (i_rs2),
        .imm    (i_imm),
        .word   (word),
        .legal  (legal)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_ready   = !i_clear && (state != FULL) &&
                    !((state == WRITE) && (o_memAddr == LAST_ADDR));
        accept    = i_valid && o_ready;
        wr        = accept && legal;
        rej       = accept && !legal;

        if (i_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, WRITE: begin
                    // The write pointer is o_count, so the word being
                    // written lands at DEPTH-1 when o_count == DEPTH-1.
                    if (wr) state_nxt = (o_count == LAST_CNT) ? FULL : WRITE;
                    else    state_nxt = IDLE;
                end
                FULL:    state_nxt = FULL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_memWrEn   <= 1'b0;
            o_memAddr   <= '0;
            o_memWrData <= '0;
            o_count     <= '0;
            o_err       <= 1'b0;
        end else if (i_clear) begin
            o_memWrEn <= 1'b0;
            o_count   <= '0;
            o_err     <= 1'b0;
        end else begin
            o_memWrEn <= wr;
            if (wr) begin
                o_memAddr   <= o_count[ADDR_W-1:0];
                o_memWrData <= word;
                o_count     <= o_count + (ADDR_W + 1)'(1);
            end
            if (rej) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    import riscv_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          valid;
    logic          ready;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [AW:0]   count;
    logic          err;

    int n_cmp = 0;
    int n_mis = 0;
    logic [AW+31:0] sb[$];
    logic [AW+31:0] sb_e;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .i_clear     (clear),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_opcode    (opcode),
        .i_funct3    (funct3),
        .i_rd        (rd),
        .i_rs1       (rs1),
        .i_rs2       (rs2),
        .i_imm       (imm),
        .o_memWrEn   (wr_en),
        .o_memAddr   (addr),
        .o_memWrData (wdata),
        .o_count     (count),
        .o_err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder written from the RV32I field layout.
    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] w;
        w = 32'd0;
        w[6:0]   = op;
        w[14:12] = f3;
        w[19:15] = s1;
        if (op == 7'b0100011) begin
            w[11:7]  = im[4:0];
            w[24:20] = s2;
            w[31:25] = im[11:5];
        end else begin
            w[11:7]  = d;
            w[31:20] = im[11:0];
        end
        return w;
    endfunction

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
        opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
        valid  = 1'b1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
        sb.push_back({a, d});
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                sb_e = sb.pop_front();
                chk("wr_addr", 64'(addr), 64'(sb_e[AW+31:32]));
                chk("wr_data", 64'(wdata), 64'(sb_e[31:0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; valid = 1'b0;
        opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_wren",  64'(wr_en), 64'd0);
        chk("rst_addr",  64'(addr),  64'd0);
        chk("rst_data",  64'(wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_err",   64'(err),   64'd0);
        rst_n = 1'b1;

        // 1: LW, then 2: SW back-to-back, then 3: ADDI, unsupported, legal
        @(negedge clk);
        drive(OPCODE_LW, 3'b010, 5'd5, 5'd2, 5'd0, 32'd8);
        push(2'd0, 32'h00812283);
        @(negedge clk);
        drive(OPCODE_SW, 3'b010, 5'd0, 5'd2, 5'd6, -32'sd4);
        push(2'd1, 32'hFE612E23);
        #1 chk("t1_count", 64'(count), 64'd1);
        @(negedge clk);
        drive(OPCODE_OPIMM, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        push(2'd2, 32'hFFF00093);
        #1 chk("t2_count", 64'(count), 64'd2);
        chk("t2_no_gap", 64'(wr_en), 64'd1);
        @(negedge clk);
        drive(7'b0110011, 3'b000, 5'd1, 5'd2, 5'd3, 32'd0);
        #1 chk("t3_count", 64'(count), 64'd3);
        chk("t3_err_before", 64'(err), 64'd0);
        @(negedge clk);
        drive(OPCODE_LW, 3'b010, 5'd3, 5'd4, 5'd0, 32'd100);
        push(2'd3, enc(OPCODE_LW, 3'b010, 5'd3, 5'd4, 5'd0, 32'd100));
        #1 chk("t3_err_set", 64'(err), 64'd1);
        chk("t3_no_strobe", 64'(wr_en), 64'd0);
        chk("t3_count_hold", 64'(count), 64'd3);
        @(negedge clk);
        valid = 1'b0;
        #1 chk("t3_count_full", 64'(count), 64'd4);
        chk("t3_ready_full", 64'(ready), 64'd0);

        // 4: clear, then stream 6 bundles with valid held into a 4-word memory
        @(negedge clk);
        clear = 1'b1;
        #1 chk("t4_ready_clear", 64'(ready), 64'd0);
        @(negedge clk);
        clear = 1'b0;
        #1 chk("t4_count_clr", 64'(count), 64'd0);
        chk("t4_err_clr", 64'(err), 64'd0);
        chk("t4_ready_clr", 64'(ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(OPCODE_OPIMM, 3'(i), 5'(i + 1), 5'(i + 7), 5'd0, 32'(i * 37 - 50));
            if (i < 4) push(2'(i), enc(OPCODE_OPIMM, 3'(i), 5'(i + 1), 5'(i + 7), 5'd0, 32'(i * 37 - 50)));
        end
        @(negedge clk);
        valid = 1'b0;
        #1 chk("t4_ready_full", 64'(ready), 64'd0);
        chk("t4_count", 64'(count), 64'd4);
        chk("t4_sb_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        drive(OPCODE_SW, 3'b010, 5'd0, 5'd9, 5'd10, 32'd2047);
        push(2'd0, enc(OPCODE_SW, 3'b010, 5'd0, 5'd9, 5'd10, 32'd2047));
        @(negedge clk);
        valid = 1'b0;
        #1 chk("t4_restart_count", 64'(count), 64'd1);

        // 5: immediate 2048 on LW
        @(negedge clk);
        drive(OPCODE_LW, 3'b010, 5'd1, 5'd1, 5'd0, 32'd2048);
`ifndef INSTR_ENCODER_RANGE_CHECK_EN
        push(2'd1, 32'h8000A083);
`endif
        @(negedge clk);
        valid = 1'b0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        #1 chk("t5_err", 64'(err), 64'd1);
        chk("t5_count", 64'(count), 64'd1);
        chk("t5_no_strobe", 64'(wr_en), 64'd0);
`else
        #1 chk("t5_err", 64'(err), 64'd0);
        chk("t5_count", 64'(count), 64'd2);
`endif

        // 6: async reset in the middle of a stream
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        drive(OPCODE_LW, 3'b001, 5'd11, 5'd12, 5'd0, 32'd4);
        push(2'd0, enc(OPCODE_LW, 3'b001, 5'd11, 5'd12, 5'd0, 32'd4));
        @(negedge clk);
        drive(OPCODE_LW, 3'b001, 5'd13, 5'd14, 5'd0, 32'd8);
        #1 chk("t6_strobe_before", 64'(wr_en), 64'd1);
        #1 rst_n = 1'b0;
        valid = 1'b0;
        #1 chk("t6_wren", 64'(wr_en), 64'd0);
        chk("t6_addr",  64'(addr),  64'd0);
        chk("t6_data",  64'(wdata), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_err",   64'(err),   64'd0);
        chk("t6_ready", 64'(ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(OPCODE_OPIMM, 3'b000, 5'd2, 5'd3, 5'd0, 32'd5);
        push(2'd0, enc(OPCODE_OPIMM, 3'b000, 5'd2, 5'd3, 5'd0, 32'd5));
        @(negedge clk);
        valid = 1'b0;
        #1 chk("t6_after_count", 64'(count), 64'd1);
        @(negedge clk);
        chk("end_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
